// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
// Receives PS/2 keyboard frames from the raw connector pins and recovers
// 8-bit scancodes. The E0 (extended) and F0 (break) prefix bytes are folded
// into flags, so the output is one strobe per key event. Parity, stop-bit
// and mid-frame inactivity are checked and reported as one-cycle strobes.
module ps2_scancode_rx #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       code_valid,
  output logic       key_release,
  output logic       extended,
  output logic       parity_err,
  output logic       frame_err
);

  // Receiver states: waiting for a start bit, shifting data, parity, stop
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Inactivity limit, held in the same width as the counter it is compared to
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  // Prefix bytes that modify the following scancode instead of being reported
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ((^data) ^ par) == 1'b1;
  endfunction

  // Pin synchronisers and edge-detect history
  logic        ps2_clk_meta_r;
  logic        ps2_clk_sync_r;
  logic        ps2_clk_prev_r;
  logic        ps2_data_meta_r;
  logic        ps2_data_sync_r;

  // Frame receiver state
  state_t      state_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic        parity_r;
  logic        ext_pend_r;
  logic        brk_pend_r;
  logic [15:0] to_cnt_r;

  // Combinational decisions derived from the registers above
  logic        fe_s;
  logic        timeout_s;
  logic        stop_bad_s;
  logic        parity_bad_s;
  logic        is_ext_s;
  logic        is_brk_s;

  // Two-flop synchronisers for both pins, plus the previous synced clock for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_meta_r  <= 1'b1;
      ps2_clk_sync_r  <= 1'b1;
      ps2_clk_prev_r  <= 1'b1;
      ps2_data_meta_r <= 1'b1;
      ps2_data_sync_r <= 1'b1;
    end else begin
      ps2_clk_meta_r  <= ps2_clk;
      ps2_clk_sync_r  <= ps2_clk_meta_r;
      ps2_clk_prev_r  <= ps2_clk_sync_r;
      ps2_data_meta_r <= ps2_data;
      ps2_data_sync_r <= ps2_data_meta_r;
    end
  end

  // Falling-edge detect, inactivity timeout and classification of the completed frame
  always_comb begin
    fe_s = ps2_clk_prev_r & ~ps2_clk_sync_r;
    // An fe in the same cycle restarts the inactivity window, so it always wins
    if ((state_r != ST_IDLE) && !fe_s && (to_cnt_r >= TO_LIMIT)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
    stop_bad_s   = ~ps2_data_sync_r;
    parity_bad_s = ~odd_parity_ok(shift_r, parity_r);
    is_ext_s     = (shift_r == CODE_EXT);
    is_brk_s     = (shift_r == CODE_BRK);
  end

  // Inactivity counter: cleared by every fe and while idle, counts during a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= 16'd0;
    end else if (fe_s || (state_r == ST_IDLE)) begin
      to_cnt_r <= 16'd0;
    end else if (to_cnt_r != 16'hFFFF) begin
      to_cnt_r <= to_cnt_r + 16'd1;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Frame FSM with prefix folding and registered event/error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      parity_r    <= 1'b0;
      ext_pend_r  <= 1'b0;
      brk_pend_r  <= 1'b0;
      scancode    <= 8'h00;
      code_valid  <= 1'b0;
      key_release <= 1'b0;
      extended    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      // Strobes are single-cycle; they are only raised below for one frame end
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (timeout_s) begin
        // Partial frame abandoned: report it and forget any prefix seen so far
        state_r    <= ST_IDLE;
        frame_err  <= 1'b1;
        ext_pend_r <= 1'b0;
        brk_pend_r <= 1'b0;
      end else if (fe_s) begin
        case (state_r)
          ST_IDLE: begin
            // A high data line here is a glitch, not a start bit; ignore it
            if (!ps2_data_sync_r) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              state_r   <= ST_IDLE;
            end
          end

          ST_DATA: begin
            // LSB arrives first, so shift in at the top and move right
            shift_r   <= {ps2_data_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end else begin
              state_r <= ST_DATA;
            end
          end

          ST_PARITY: begin
            parity_r <= ps2_data_sync_r;
            state_r  <= ST_STOP;
          end

          ST_STOP: begin
            state_r <= ST_IDLE;
            if (stop_bad_s) begin
              frame_err  <= 1'b1;
              ext_pend_r <= 1'b0;
              brk_pend_r <= 1'b0;
            end else if (parity_bad_s) begin
              parity_err <= 1'b1;
              ext_pend_r <= 1'b0;
              brk_pend_r <= 1'b0;
            end else if (is_ext_s) begin
              ext_pend_r <= 1'b1;
            end else if (is_brk_s) begin
              brk_pend_r <= 1'b1;
            end else begin
              // Final byte of a key event: publish it with the accumulated prefixes
              scancode    <= shift_r;
              extended    <= ext_pend_r;
              key_release <= brk_pend_r;
              code_valid  <= 1'b1;
              ext_pend_r  <= 1'b0;
              brk_pend_r  <= 1'b0;
            end
          end

          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Testbench for ps2_scancode_rx: drives PS/2 frames on the pins and checks
// decoded events and error strobes against constants and a byte-level model.
module tb_ps2_scancode_rx;

  localparam int TO   = 200;  // timeout used by this bench
  localparam int HALF = 20;   // clk cycles per PS/2 clock half-period

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       code_valid;
  logic       key_release;
  logic       extended;
  logic       parity_err;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  // Monitor state
  ev_t obs_q[$];
  int  n_perr = 0;
  int  n_ferr = 0;
  int  n_multi = 0;
  int  cyc = 0;
  int  last_cv_cyc = 0;
  int  pin_fall_cyc = 0;

  // Reference model state
  ev_t exp_q[$];
  int  exp_perr = 0;
  int  exp_ferr = 0;
  bit  m_ext = 1'b0;
  bit  m_brk = 1'b0;

  ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scancode   (scancode),
    .code_valid (code_valid),
    .key_release(key_release),
    .extended   (extended),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // Capture events and strobes away from the active edge
  always @(negedge clk) begin
    if (code_valid === 1'b1) begin
      obs_q.push_back({scancode, extended, key_release});
      last_cv_cyc = cyc;
    end
    if (parity_err === 1'b1) n_perr++;
    if (frame_err === 1'b1) n_ferr++;
    if ((int'(code_valid === 1'b1) + int'(parity_err === 1'b1) + int'(frame_err === 1'b1)) > 1)
      n_multi++;
  end

  // Watchdog so the run can never hang
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // 11-bit frame, bit 0 first on the wire: start, data LSB first, odd parity, stop
  function automatic logic [10:0] frame_word(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b);
    if (bad_par) par = ~par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  // Byte-level reference: what the key-event stream should look like
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_stop) begin
      exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (bad_par) begin
      exp_perr++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_q.push_back({b, m_ext, m_brk});
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    pin_fall_cyc = cyc;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive_bit(f[i]);
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    send_bits(frame_word(b, bad_par, bad_stop), 0, 10);
  endtask

  task automatic test_reset;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({scancode, code_valid, key_release, extended, parity_err, frame_err} !== 13'h0) begin
      errors++;
      $display("FAIL reset_held: outputs=%h required=0", {scancode, code_valid, key_release, extended, parity_err, frame_err});
    end
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({scancode, code_valid, key_release, extended, parity_err, frame_err} !== 13'h0) begin
      errors++;
      $display("FAIL reset_released: outputs=%h required=0", {scancode, code_valid, key_release, extended, parity_err, frame_err});
    end
  endtask

  task automatic test_single_make;
    int base;
    base = obs_q.size();
    send_frame(8'h1C);
    checks++;
    if (obs_q.size() - base !== 1) begin
      errors++; $display("FAIL make_count: got %0d events required 1", obs_q.size() - base);
    end else begin
      checks++;
      if (obs_q[base] !== {8'h1C, 1'b0, 1'b0}) begin
        errors++; $display("FAIL make_event: got %h required %h", obs_q[base], {8'h1C, 1'b0, 1'b0});
      end
    end
    checks++;
    if (last_cv_cyc - pin_fall_cyc !== 3) begin
      errors++; $display("FAIL make_latency: got %0d cycles required 3", last_cv_cyc - pin_fall_cyc);
    end
    checks++;
    if ({scancode, code_valid} !== {8'h1C, 1'b0}) begin
      errors++; $display("FAIL make_hold: scancode=%h code_valid=%b required 1c/0", scancode, code_valid);
    end
  endtask

  task automatic test_break;
    int base;
    base = obs_q.size();
    send_frame(8'hF0);
    checks++;
    if (obs_q.size() !== base) begin
      errors++; $display("FAIL break_prefix_silent: got %0d events required 0", obs_q.size() - base);
    end
    send_frame(8'h1C);
    send_frame(8'h1C);
    checks++;
    if (obs_q.size() - base !== 2) begin
      errors++; $display("FAIL break_count: got %0d events required 2", obs_q.size() - base);
    end else begin
      checks++;
      if (obs_q[base] !== {8'h1C, 1'b0, 1'b1}) begin
        errors++; $display("FAIL break_event: got %h required %h", obs_q[base], {8'h1C, 1'b0, 1'b1});
      end
      checks++;
      if (obs_q[base+1] !== {8'h1C, 1'b0, 1'b0}) begin
        errors++; $display("FAIL break_cleared: got %h required %h", obs_q[base+1], {8'h1C, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_parity;
    int base, pe;
    base = obs_q.size(); pe = n_perr;
    send_frame(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b0);
    checks++;
    if (n_perr - pe !== 1 || obs_q.size() !== base) begin
      errors++; $display("FAIL parity_err: got perr=%0d events=%0d required 1/0", n_perr - pe, obs_q.size() - base);
    end
    send_frame(8'h1C);
    checks++;
    if (obs_q.size() - base !== 1 || obs_q[obs_q.size()-1] !== {8'h1C, 1'b0, 1'b0}) begin
      errors++; $display("FAIL parity_recover: got %0d events last=%h required 1 event 1c/0/0",
                         obs_q.size() - base, obs_q[obs_q.size()-1]);
    end
  endtask

  task automatic test_timeout;
    int base, fe0;
    base = obs_q.size();
    send_frame(8'hE0);
    fe0 = n_ferr;
    send_bits(frame_word(8'h29, 1'b0, 1'b0), 0, 4);
    repeat (TO + 100) @(posedge clk);
    checks++;
    if (n_ferr - fe0 !== 1 || obs_q.size() !== base) begin
      errors++; $display("FAIL timeout_ferr: got ferr=%0d events=%0d required 1/0", n_ferr - fe0, obs_q.size() - base);
    end
    send_frame(8'h29);
    checks++;
    if (obs_q.size() - base !== 1 || obs_q[obs_q.size()-1] !== {8'h29, 1'b0, 1'b0}) begin
      errors++; $display("FAIL timeout_recover: got %0d events last=%h required 1 event 29/0/0",
                         obs_q.size() - base, obs_q[obs_q.size()-1]);
    end
  endtask

  task automatic test_spurious;
    int base, pe, fe0;
    base = obs_q.size(); pe = n_perr; fe0 = n_ferr;
    drive_bit(1'b1);
    repeat (TO + 50) @(posedge clk);
    send_frame(8'h1C);
    checks++;
    if (n_perr !== pe || n_ferr !== fe0 || obs_q.size() - base !== 1 || obs_q[obs_q.size()-1] !== {8'h1C, 1'b0, 1'b0}) begin
      errors++; $display("FAIL spurious_start: perr=%0d ferr=%0d events=%0d required 0/0/1",
                         n_perr - pe, n_ferr - fe0, obs_q.size() - base);
    end
  endtask

  task automatic test_ext_break;
    int base;
    base = obs_q.size();
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h74);
    checks++;
    if (obs_q.size() - base !== 1) begin
      errors++; $display("FAIL extbrk_count: got %0d events required 1", obs_q.size() - base);
    end else begin
      checks++;
      if (obs_q[base] !== {8'h74, 1'b1, 1'b1}) begin
        errors++; $display("FAIL extbrk_event: got %h required %h", obs_q[base], {8'h74, 1'b1, 1'b1});
      end
    end
  endtask

  task automatic test_reset_mid;
    int base, pe, fe0;
    logic [10:0] f;
    f = frame_word(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0);
    send_bits(f, 0, 5);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({scancode, code_valid, key_release, extended, parity_err, frame_err} !== 13'h0) begin
      errors++; $display("FAIL reset_mid_outputs: outputs=%h required 0",
                         {scancode, code_valid, key_release, extended, parity_err, frame_err});
    end
    base = obs_q.size(); pe = n_perr; fe0 = n_ferr;
    send_bits(f, 6, 10);
    repeat (TO + 100) @(posedge clk);
    checks++;
    if (obs_q.size() !== base || n_perr !== pe || n_ferr - fe0 > 1) begin
      errors++; $display("FAIL reset_mid_tail: events=%0d perr=%0d ferr=%0d required 0/0/<=1",
                         obs_q.size() - base, n_perr - pe, n_ferr - fe0);
    end
    send_frame(8'h1C);
    checks++;
    if (obs_q.size() - base !== 1 || obs_q[obs_q.size()-1] !== {8'h1C, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_mid_recover: events=%0d last=%h required 1 event 1c/0/0",
                         obs_q.size() - base, obs_q[obs_q.size()-1]);
    end
  endtask

  task automatic test_random;
    int base, pe, fe0, r;
    logic [7:0] b;
    bit bp, bs;
    base = obs_q.size(); pe = n_perr; fe0 = n_ferr;
    exp_q.delete(); exp_perr = 0; exp_ferr = 0; m_ext = 1'b0; m_brk = 1'b0;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2)      b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else            b = 8'($urandom_range(0, 255));
      r = int'($urandom_range(0, 11));
      bp = (r == 0);
      bs = (r == 1);
      model_frame(b, bp, bs);
      send_frame(b, bp, bs);
    end
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d events required %0d", obs_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[base+i] !== exp_q[i]) begin
          errors++; $display("FAIL random_event[%0d]: got %h required %h", i, obs_q[base+i], exp_q[i]);
        end
      end
    end
    checks++;
    if (n_perr - pe !== exp_perr) begin
      errors++; $display("FAIL random_perr: got %0d required %0d", n_perr - pe, exp_perr);
    end
    checks++;
    if (n_ferr - fe0 !== exp_ferr) begin
      errors++; $display("FAIL random_ferr: got %0d required %0d", n_ferr - fe0, exp_ferr);
    end
  endtask

  task automatic test_exclusive;
    checks++;
    if (n_multi !== 0) begin
      errors++; $display("FAIL strobe_exclusive: got %0d overlapping cycles required 0", n_multi);
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_break();
    test_parity();
    test_timeout();
    test_spurious();
    test_ext_break();
    test_reset_mid();
    test_random();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
